// File: rtl/spi_master_ctrl_pkg.sv
// Shared SPI master definitions: frame geometry, R/W encoding, FSM state encoding.
package spi_master_ctrl_pkg;

  localparam int unsigned SPI_ADDR_W  = 7;
  localparam int unsigned SPI_DATA_W  = 8;
  localparam int unsigned SPI_FRAME_W = 16;

  localparam logic SPI_RW_READ  = 1'b1;
  localparam logic SPI_RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    SPIM_IDLE  = 2'd0,
    SPIM_SETUP = 2'd1,
    SPIM_SHIFT = 2'd2,
    SPIM_HOLD  = 2'd3
  } spim_state_e;

  // Read frames carry zeros in the data slot so mosi stays low while data comes back.
  function automatic logic [SPI_FRAME_W-1:0] spim_frame(
    input logic [SPI_ADDR_W-1:0] addr,
    input logic                  rw,
    input logic [SPI_DATA_W-1:0] wdata
  );
    return {addr, rw, (rw == SPI_RW_READ) ? {SPI_DATA_W{1'b0}} : wdata};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period counter producing sclk plus rise/fall strobes.
// Strobes are high in the cycle before the edge that changes sclk; idle low when disabled.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned   CW   = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          wrap;

  assign wrap   = en_i && (cnt_q == LAST);
  assign rise_o = wrap && !sclk_q;
  assign fall_o = wrap && sclk_q;
  assign sclk_o = sclk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Handshake-driven SPI mode-0 master issuing 16-bit {addr,rw,data} frames to the SPI memory.
// Optional debug LEDs enabled by defining SPI_MASTER_DEBUG_LEDS_EN.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned CS_SETUP_CYCLES = 2,
  parameter int unsigned CS_HOLD_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic                  req_rw,
  input  logic [SPI_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [SPI_DATA_W-1:0] rsp_rdata,
  output logic                  sclk,
  output logic                  cs,
  output logic                  mosi,
  input  logic                  miso,
  output logic [3:0]            leds
);

  localparam int unsigned   PH_MAX     = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int unsigned   PW         = $clog2(PH_MAX) + 1;
  localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD_CYCLES - 1);

  spim_state_e                  state_q;
  logic                         ready_q, cs_q, mosi_q, rsp_valid_q, rw_q;
  logic [SPI_FRAME_W-2:0]       tx_q;
  logic [SPI_DATA_W-1:0]        rx_q, rdata_q;
  logic [PW-1:0]                phase_q;
  logic [4:0]                   bit_q;
  logic [SPI_FRAME_W-1:0]       frame;
  logic                         rise, fall, hold_done;

  assign frame     = spim_frame(req_addr, req_rw, req_wdata);
  assign hold_done = (state_q == SPIM_HOLD) && (phase_q == HOLD_LAST);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (state_q == SPIM_SHIFT),
    .sclk_o (sclk),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SPIM_IDLE;
      ready_q     <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rw_q        <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      phase_q     <= '0;
      bit_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        SPIM_IDLE: begin
          ready_q <= 1'b1;
          cs_q    <= 1'b1;
          mosi_q  <= 1'b0;
          if (req_valid && ready_q) begin
            // MSB goes straight onto mosi; tx_q keeps only the bits still to send.
            tx_q    <= frame[SPI_FRAME_W-2:0];
            mosi_q  <= frame[SPI_FRAME_W-1];
            rw_q    <= req_rw;
            cs_q    <= 1'b0;
            ready_q <= 1'b0;
            phase_q <= '0;
            state_q <= SPIM_SETUP;
          end
        end
        SPIM_SETUP: begin
          if (phase_q == SETUP_LAST) begin
            phase_q <= '0;
            bit_q   <= '0;
            state_q <= SPIM_SHIFT;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        SPIM_SHIFT: begin
          if (rise) begin
            rx_q <= {rx_q[SPI_DATA_W-2:0], miso};
          end
          if (fall) begin
            bit_q  <= bit_q + 5'd1;
            tx_q   <= {tx_q[SPI_FRAME_W-3:0], 1'b0};
            mosi_q <= tx_q[SPI_FRAME_W-2];
            if (bit_q == 5'd15) begin
              mosi_q  <= 1'b0;
              phase_q <= '0;
              state_q <= SPIM_HOLD;
            end
          end
        end
        SPIM_HOLD: begin
          if (hold_done) begin
            cs_q        <= 1'b1;
            rsp_valid_q <= 1'b1;
            ready_q     <= 1'b1;
            if (rw_q == SPI_RW_READ) rdata_q <= rx_q;
            phase_q     <= '0;
            state_q     <= SPIM_IDLE;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign cs        = cs_q;
  assign mosi      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

`ifdef SPI_MASTER_DEBUG_LEDS_EN
  logic last_rd_q, done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_rd_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (hold_done) begin
      last_rd_q <= rw_q;
      done_q    <= 1'b1;
    end
  end

  assign leds = {done_q, last_rd_q, state_q};
`else
  assign leds = '0;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI memory slave and a response scoreboard.
module tb_spi_master_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: default parameters, index 1: CLK_DIV=1, setup/hold=1.
  logic [1:0]      req_valid_v = '0;
  logic [1:0]      req_rw_v    = '0;
  logic [1:0][6:0] req_addr_v  = '0;
  logic [1:0][7:0] req_wdata_v = '0;
  logic [1:0]      miso_v      = '1;

  logic       ready0, rspv0, sclk0, cs0, mosi0;
  logic       ready1, rspv1, sclk1, cs1, mosi1;
  logic [7:0] rdata0, rdata1;
  logic [3:0] leds0, leds1;

  logic [1:0]      ready_v, rsp_valid_v, sclk_v, cs_v, mosi_v;
  logic [1:0][7:0] rdata_v;
  logic [1:0][3:0] leds_v;
  assign ready_v     = {ready1, ready0};
  assign rsp_valid_v = {rspv1, rspv0};
  assign sclk_v      = {sclk1, sclk0};
  assign cs_v        = {cs1, cs0};
  assign mosi_v      = {mosi1, mosi0};
  assign rdata_v     = {rdata1, rdata0};
  assign leds_v      = {leds1, leds0};

  spi_master_ctrl dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_ready(ready0),
    .req_addr(req_addr_v[0]), .req_rw(req_rw_v[0]), .req_wdata(req_wdata_v[0]),
    .rsp_valid(rspv0), .rsp_rdata(rdata0), .sclk(sclk0), .cs(cs0), .mosi(mosi0),
    .miso(miso_v[0]), .leds(leds0)
  );

  spi_master_ctrl #(.CLK_DIV(1), .CS_SETUP_CYCLES(1), .CS_HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_ready(ready1),
    .req_addr(req_addr_v[1]), .req_rw(req_rw_v[1]), .req_wdata(req_wdata_v[1]),
    .rsp_valid(rspv1), .rsp_rdata(rdata1), .sclk(sclk1), .cs(cs1), .mosi(mosi1),
    .miso(miso_v[1]), .leds(leds1)
  );

`ifdef SPI_MASTER_DEBUG_LEDS_EN
  localparam logic [1:0] LED_MID = 2'd2;
  localparam logic       DBG     = 1'b1;
`else
  localparam logic [1:0] LED_MID = 2'd0;
  localparam logic       DBG     = 1'b0;
`endif

  // Bus monitors and SPI memory slave, sampled on the falling clk edge.
  logic [1:0]  sclk_p = '0, mosi_p = '0;
  int unsigned rises[2], cslow[2], viol[2], rsps[2], led_nz[2], s_cnt[2];
  logic [15:0] mbits[2];
  logic [6:0]  s_addr[2];
  logic        s_rw[2];
  logic [7:0]  smem[2][128];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!cs_v[k]) cslow[k] <= cslow[k] + 1;
      if (rsp_valid_v[k]) rsps[k] <= rsps[k] + 1;
      if (leds_v[k] != 4'h0) led_nz[k] <= led_nz[k] + 1;
      if (sclk_v[k] && sclk_p[k] && (mosi_v[k] != mosi_p[k])) viol[k] <= viol[k] + 1;
      if (cs_v[k]) begin
        s_cnt[k]  <= 0;
        miso_v[k] <= 1'b1;
      end else if (sclk_v[k] && !sclk_p[k]) begin
        rises[k] <= rises[k] + 1;
        mbits[k] <= {mbits[k][14:0], mosi_v[k]};
        s_cnt[k] <= s_cnt[k] + 1;
        if (s_cnt[k] == 7) begin
          s_addr[k] <= mbits[k][6:0];
          s_rw[k]   <= mosi_v[k];
        end
        if (s_cnt[k] == 15 && !s_rw[k]) smem[k][s_addr[k]] <= {mbits[k][6:0], mosi_v[k]};
      end else if (!sclk_v[k] && sclk_p[k]) begin
        if (s_cnt[k] >= 8 && s_cnt[k] < 16 && s_rw[k])
          miso_v[k] <= smem[k][s_addr[k]][3'(15 - s_cnt[k])];
        else
          miso_v[k] <= 1'b1;
      end
    end
    sclk_p <= sclk_v;
    mosi_p <= mosi_v;
  end

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  exp_mem[2][128];
  logic [7:0]  exp_rd[2];
  int unsigned acc_cyc[2], rsp_cyc[2];
  int unsigned snap_rises[2], snap_cslow[2], snap_viol[2];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic do_req(input int k, input logic [6:0] addr, input logic rw,
                        input logic [7:0] wdata, input bit hold);
    exp_t e;
    int   n;
    req_addr_v[k]  = addr;
    req_rw_v[k]    = rw;
    req_wdata_v[k] = wdata;
    req_valid_v[k] = 1'b1;
    n = 0;
    while (!ready_v[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 500), 32'd1);
    e.frame = {addr, rw, rw ? 8'h00 : wdata};
    if (rw) begin
      e.rdata   = exp_mem[k][addr];
      exp_rd[k] = e.rdata;
    end else begin
      exp_mem[k][addr] = wdata;
      e.rdata          = exp_rd[k];
    end
    e.lat = (k == 0) ? 132 : 34;
    sb.push_back(e);
    snap_rises[k] = rises[k];
    snap_cslow[k] = cslow[k];
    snap_viol[k]  = viol[k];
    @(negedge clk);
    acc_cyc[k] = cyc;
    if (hold) begin
      req_addr_v[k]  = 7'h55;
      req_rw_v[k]    = ~rw;
      req_wdata_v[k] = ~wdata;
    end else begin
      req_valid_v[k] = 1'b0;
    end
  endtask

  // Returns at the negedge where rsp_valid is observed high.
  task automatic wait_rsp(input int k);
    exp_t e;
    int   n, rdy;
    n   = 0;
    rdy = 0;
    do begin
      @(negedge clk);
      n++;
      if (ready_v[k] && !rsp_valid_v[k]) rdy++;
      if (k == 0 && n == 60) chk("leds_mid_shift", 32'(leds_v[0][1:0]), 32'(LED_MID));
    end while (!rsp_valid_v[k] && n < 1000);
    rsp_cyc[k] = cyc;
    e = sb.pop_front();
    chk("latency", cyc - acc_cyc[k], e.lat);
    chk("cs_low_cycles", cslow[k] - snap_cslow[k], e.lat);
    chk("sclk_rises", rises[k] - snap_rises[k], 32'd16);
    chk("mosi_frame", 32'(mbits[k]), 32'(e.frame));
    chk("mosi_while_high", viol[k] - snap_viol[k], 32'd0);
    chk("ready_while_busy", 32'(rdy), 32'd0);
    chk("rsp_rdata", 32'(rdata_v[k]), 32'(e.rdata));
  endtask

  initial begin
    int unsigned snap;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 32'(ready_v[k]), 32'd0);
      chk("rst_cs", 32'(cs_v[k]), 32'd1);
      chk("rst_sclk_mosi", 32'({sclk_v[k], mosi_v[k]}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid_v[k], rdata_v[k]}), 32'd0);
      chk("rst_leds", 32'(leds_v[k]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(ready_v), 32'd3);

    // Write, then confirm the response is a single-cycle pulse.
    do_req(0, 7'h01, 1'b0, 8'hAA, 1'b0);
    wait_rsp(0);
    @(negedge clk);
    chk("rsp_pulse_width", 32'(rsp_valid_v[0]), 32'd0);
    chk("leds_done", 32'(leds_v[0][3]), 32'(DBG));
    chk("leds_last_write", 32'(leds_v[0][2]), 32'd0);

    do_req(0, 7'h01, 1'b1, 8'h00, 1'b0);
    wait_rsp(0);
    do_req(0, 7'h7F, 1'b0, 8'h55, 1'b0);
    wait_rsp(0);
    do_req(0, 7'h7F, 1'b1, 8'hFF, 1'b0);
    wait_rsp(0);
    chk("leds_last_read", 32'(leds_v[0][2]), 32'(DBG));

    // req_valid held with changed fields through the frame must not start a second frame.
    do_req(0, 7'h22, 1'b0, 8'h3C, 1'b1);
    wait_rsp(0);
    req_valid_v[0] = 1'b0;
    snap = cslow[0];
    repeat (20) @(negedge clk);
    chk("no_second_frame", cslow[0] - snap, 32'd0);
    do_req(0, 7'h22, 1'b1, 8'h00, 1'b0);
    wait_rsp(0);

    // Reset 40 cycles into a read abandons the frame.
    do_req(0, 7'h7F, 1'b1, 8'h00, 1'b0);
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cs", 32'(cs_v[0]), 32'd1);
    chk("midrst_sclk_mosi", 32'({sclk_v[0], mosi_v[0]}), 32'd0);
    chk("midrst_rdata", 32'(rdata_v[0]), 32'd0);
    void'(sb.pop_back());
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    snap = rsps[0];
    reset = 1'b0;
    repeat (150) @(negedge clk);
    chk("midrst_no_rsp", rsps[0] - snap, 32'd0);
    chk("midrst_rdata_held", 32'(rdata_v[0]), 32'd0);
    do_req(0, 7'h01, 1'b1, 8'h00, 1'b0);
    wait_rsp(0);

    // Fast configuration: populate memory, then back-to-back reads.
    do_req(1, 7'h01, 1'b0, 8'hAA, 1'b0);
    wait_rsp(1);
    do_req(1, 7'h7F, 1'b0, 8'h55, 1'b0);
    wait_rsp(1);
    do_req(1, 7'h01, 1'b1, 8'h00, 1'b0);
    wait_rsp(1);
    do_req(1, 7'h7F, 1'b1, 8'h00, 1'b0);
    chk("b2b_gap", acc_cyc[1] - rsp_cyc[1], 32'd1);
    chk("b2b_cs_low", 32'(cs_v[1]), 32'd0);
    wait_rsp(1);

`ifndef SPI_MASTER_DEBUG_LEDS_EN
    chk("leds_zero", led_nz[0] + led_nz[1], 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
